// File: rtl/eth_gmii_tx_if.sv
// eth_gmii_tx_if: AXI-Stream byte input plus GMII transmit and status outputs of eth_gmii_tx.
interface eth_gmii_tx_if;
    logic [7:0] axis_tdata_in;
    logic       axis_tvalid_in;
    logic       axis_tlast_in;
    logic       axis_tready_out;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       tx_busy;
    logic       frame_sent;
    logic       tx_underflow;
    modport slave (
        input  axis_tdata_in, axis_tvalid_in, axis_tlast_in,
        output axis_tready_out, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_sent, tx_underflow
    );
    modport master (
        output axis_tdata_in, axis_tvalid_in, axis_tlast_in,
        input  axis_tready_out, gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, frame_sent, tx_underflow
    );
endinterface

// File: rtl/eth_gmii_tx.sv
// eth_gmii_tx: byte-wide Ethernet framer adding preamble/SFD, padding, CRC-32 FCS and inter-frame gap.
module eth_gmii_tx #(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_FRAME  = 60,
    parameter int MAX_FRAME  = 1514,
    parameter bit ENABLE_PAD = 1'b1
) (
    input logic          clk_8,
    input logic          reset_8_n,
    eth_gmii_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG, DRAIN} state_t;
    localparam logic [15:0] MIN_L = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_L = 16'(MAX_FRAME);
    localparam logic [15:0] IFG_L = 16'(IFG_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d, er_q, er_d, sent_q, sent_d, uf_q, uf_d;
    logic        short_frame;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign cnt_inc     = cnt_q + 16'd1;
    assign short_frame = ENABLE_PAD && cnt_inc < MIN_L;

    // cnt_q is reused: preamble index, byte count, FCS index, then IFG count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        sent_d  = 1'b0;
        uf_d    = 1'b0;
        case (state_q)
            IDLE: begin
                crc_d = '1;
                cnt_d = '0;
                if (bus.axis_tvalid_in) begin
                    state_d = PRE;
                    txd_d   = 8'h55;
                    en_d    = 1'b1;
                end
            end
            PRE: begin
                en_d    = 1'b1;
                txd_d   = cnt_q == 16'd6 ? 8'hD5 : 8'h55;
                cnt_d   = cnt_q == 16'd6 ? 16'd0 : cnt_inc;
                state_d = cnt_q == 16'd6 ? DATA : PRE;
            end
            DATA: begin
                en_d = 1'b1;
                if (!bus.axis_tvalid_in || (!bus.axis_tlast_in && cnt_inc == MAX_L)) begin
                    er_d    = 1'b1;
                    uf_d    = 1'b1;
                    state_d = DRAIN;
                end else begin
                    txd_d = bus.axis_tdata_in;
                    crc_d = crc_step(crc_q, bus.axis_tdata_in);
                    cnt_d = cnt_inc;
                    if (bus.axis_tlast_in) begin
                        state_d = short_frame ? PAD : FCS;
                        cnt_d   = short_frame ? cnt_inc : 16'd0;
                    end
                end
            end
            PAD: begin
                en_d    = 1'b1;
                crc_d   = crc_step(crc_q, 8'h00);
                cnt_d   = cnt_inc == MIN_L ? 16'd0 : cnt_inc;
                state_d = cnt_inc == MIN_L ? FCS : PAD;
            end
            FCS: begin
                en_d    = 1'b1;
                txd_d   = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
                sent_d  = cnt_q == 16'd3;
                cnt_d   = cnt_q == 16'd3 ? 16'd0 : cnt_inc;
                state_d = cnt_q == 16'd3 ? IFG : FCS;
            end
            IFG: begin
                cnt_d   = cnt_q == IFG_L ? 16'd0 : cnt_inc;
                state_d = cnt_q == IFG_L ? IDLE : IFG;
            end
            DRAIN: begin
                if (bus.axis_tvalid_in && bus.axis_tlast_in) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_8 or negedge reset_8_n) begin
        if (!reset_8_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= '1;
            txd_q   <= '0;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            sent_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            en_q    <= en_d;
            er_q    <= er_d;
            sent_q  <= sent_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.axis_tready_out = state_q == DATA || state_q == DRAIN;
    assign bus.tx_busy         = state_q != IDLE;
    assign bus.gmii_txd        = txd_q;
    assign bus.gmii_tx_en      = en_q;
    assign bus.gmii_tx_er      = er_q;
    assign bus.frame_sent      = sent_q;
    assign bus.tx_underflow    = uf_q;
endmodule

// File: tb/tb_eth_gmii_tx.sv
// tb_eth_gmii_tx: three framer instances (default, no padding, MAX_FRAME=64) checked against a frame-level model.
module tb_eth_gmii_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic [1:0] sel = 2'd0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    eth_gmii_tx_if if_a ();
    eth_gmii_tx_if if_n ();
    eth_gmii_tx_if if_m ();

    eth_gmii_tx dut_a (.clk_8(clk), .reset_8_n(rst_n), .bus(if_a));
    eth_gmii_tx #(.ENABLE_PAD(1'b0)) dut_n (.clk_8(clk), .reset_8_n(rst_n), .bus(if_n));
    eth_gmii_tx #(.MAX_FRAME(64)) dut_m (.clk_8(clk), .reset_8_n(rst_n), .bus(if_m));

    assign if_a.axis_tdata_in  = tdata;
    assign if_n.axis_tdata_in  = tdata;
    assign if_m.axis_tdata_in  = tdata;
    assign if_a.axis_tlast_in  = tlast;
    assign if_n.axis_tlast_in  = tlast;
    assign if_m.axis_tlast_in  = tlast;
    assign if_a.axis_tvalid_in = tvalid && sel == 2'd0;
    assign if_n.axis_tvalid_in = tvalid && sel == 2'd1;
    assign if_m.axis_tvalid_in = tvalid && sel == 2'd2;

    logic [13:0] o_a, o_n, o_m, o;
    assign o_a = {if_a.axis_tready_out, if_a.gmii_txd, if_a.gmii_tx_en, if_a.gmii_tx_er, if_a.tx_busy, if_a.frame_sent, if_a.tx_underflow};
    assign o_n = {if_n.axis_tready_out, if_n.gmii_txd, if_n.gmii_tx_en, if_n.gmii_tx_er, if_n.tx_busy, if_n.frame_sent, if_n.tx_underflow};
    assign o_m = {if_m.axis_tready_out, if_m.gmii_txd, if_m.gmii_tx_en, if_m.gmii_tx_er, if_m.tx_busy, if_m.frame_sent, if_m.tx_underflow};
    assign o   = sel == 2'd0 ? o_a : sel == 2'd1 ? o_n : o_m;

    logic       m_rdy, m_en, m_er, m_busy, m_sent, m_uf;
    logic [7:0] m_txd;
    assign {m_rdy, m_txd, m_en, m_er, m_busy, m_sent, m_uf} = o;

    // Monitor: every tx_en cycle is logged as {tx_er, txd}; gaps hold the low run before each rising tx_en
    logic [8:0] cap[$];
    int         gaps[$];
    int         en_tot = 0, sent_tot = 0, uf_tot = 0, rdy_tot = 0, low_run = 0;
    logic       prev_en = 1'b0;
    always @(negedge clk) begin
        if (m_en) cap.push_back({m_er, m_txd});
        if (m_en && !prev_en) gaps.push_back(low_run);
        low_run  <= m_en ? 0 : low_run + 1;
        en_tot   <= en_tot + int'(m_en);
        sent_tot <= sent_tot + int'(m_sent);
        uf_tot   <= uf_tot + int'(m_uf);
        rdy_tot  <= rdy_tot + int'(m_rdy);
        prev_en  <= m_en;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] crc32(input logic [7:0] q[$]);
        logic [31:0] c;
        logic        fb;
        c = '1;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    // Expected GMII activity of one frame: preamble, data (or the truncated prefix plus one error cycle), pad, FCS
    function automatic void model(input logic [7:0] q[$], input logic [1:0] s, input int drop,
                                  output logic [8:0] w[$], output int se, output int ue);
        logic [7:0]  body[$];
        logic [31:0] f;
        int          mx, cut;
        mx  = s == 2'd2 ? 64 : 1514;
        cut = drop;
        if (q.size() > mx && (cut < 0 || cut > mx - 1)) cut = mx - 1;
        w = {};
        for (int i = 0; i < 8; i++) w.push_back(i == 7 ? 9'h0D5 : 9'h055);
        if (cut >= 0) begin
            for (int i = 0; i < cut; i++) w.push_back({1'b0, q[i]});
            w.push_back(9'h100);
            se = 0;
            ue = 1;
        end else begin
            body = q;
            while (s != 2'd1 && body.size() < 60) body.push_back(8'h00);
            f = crc32(body);
            foreach (body[i]) w.push_back({1'b0, body[i]});
            for (int i = 0; i < 4; i++) w.push_back({1'b0, f[8*i +: 8]});
            se = 1;
            ue = 0;
        end
    endfunction

    task automatic make_frame(input int kind, input int len, output logic [7:0] q[$]);
        logic [7:0] hdr[14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
        q = {};
        for (int i = 0; i < len; i++)
            q.push_back(kind == 0 ? 8'h31 + 8'(i) : (kind == 1 && i < 14) ? hdr[i] : 8'($urandom));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds tvalid except for one cycle at byte index drop while tready is high
    task automatic send_frame(input logic [7:0] q[$], input int drop);
        int   i = 0, cyc = 0;
        bit   dropped = 1'b0;
        logic rdy;
        while (i < q.size() && cyc < 4000) begin
            rdy    = m_rdy;
            tvalid = !(drop == i && rdy && !dropped);
            if (!tvalid) dropped = 1'b1;
            tdata = q[i];
            tlast = i == q.size() - 1;
            cycles(1);
            if (rdy && tvalid) i++;
            cyc++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        check("all_bytes_accepted", i, q.size());
    endtask

    task automatic wait_idle();
        int c = 0;
        while (m_busy && c < 300) begin
            cycles(1);
            c++;
        end
        check("returned_to_idle", m_busy, 0);
        cycles(2);
    endtask

    task automatic cmp_wire(input string tag, input int base, input logic [8:0] w[$]);
        int idx = w.size() - 1;
        for (int i = w.size() - 1; i >= 0; i--)
            if (base + i >= cap.size() || cap[base + i] !== w[i]) idx = i;
        check({tag, " len"}, cap.size() - base, w.size());
        check($sformatf("%s wire[%0d]", tag, idx), base + idx < cap.size() ? cap[base + idx] : 9'h1FF, w[idx]);
    endtask

    task automatic run_frame(input string tag, input logic [1:0] s, input logic [7:0] q[$], input int drop,
                             input int en_exp, input int se_exp, input int ue_exp);
        logic [8:0] w[$];
        int         se, ue, b_cap, b_en, b_sent, b_uf;
        sel = s;
        model(q, s, drop, w, se, ue);
        b_cap  = cap.size();
        b_en   = en_tot;
        b_sent = sent_tot;
        b_uf   = uf_tot;
        send_frame(q, drop);
        wait_idle();
        cmp_wire(tag, b_cap, w);
        check({tag, " en_cycles"}, en_tot - b_en, en_exp >= 0 ? en_exp : w.size());
        check({tag, " frame_sent"}, sent_tot - b_sent, se_exp >= 0 ? se_exp : se);
        check({tag, " underflow"}, uf_tot - b_uf, ue_exp >= 0 ? ue_exp : ue);
    endtask

    typedef struct {
        logic [1:0] sel;
        int         kind;
        int         len;
        int         drop;
        int         en_exp;
        int         sent_exp;
        int         uf_exp;
    } vec_t;

    vec_t vt[13] = '{
        '{2'd1, 0, 9,   -1, 21, 1, 0},
        '{2'd0, 1, 14,  -1, 72, 1, 0},
        '{2'd0, 2, 100, 20, 29, 0, 1},
        '{2'd0, 2, 64,  -1, 76, 1, 0},
        '{2'd2, 2, 70,  -1, 72, 0, 1},
        '{2'd2, 2, 64,  -1, 76, 1, 0},
        '{2'd2, 2, 63,  -1, 75, 1, 0},
        '{2'd0, 2, 59,  -1, 72, 1, 0},
        '{2'd0, 2, 60,  -1, 72, 1, 0},
        '{2'd0, 2, 61,  -1, 73, 1, 0},
        '{2'd0, 2, 1,   -1, 72, 1, 0},
        '{2'd1, 2, 1,   -1, 13, 1, 0},
        '{2'd0, 2, 5,   0,  9,  0, 1}
    };

    initial begin
        logic [7:0]  q[$], q2[$];
        logic [8:0]  w1[$], w2[$];
        logic [31:0] fcs;
        int          se, ue, b_cap, b_sent, b_rdy, len, drop;
        logic [1:0]  s;

        cycles(3);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            check($sformatf("reset_outputs dut%0d", k), o, 0);
        end
        rst_n = 1'b1;
        cycles(2);

        for (int v = 0; v < 13; v++) begin
            make_frame(vt[v].kind, vt[v].len, q);
            run_frame($sformatf("vec%0d", v), vt[v].sel, q, vt[v].drop, vt[v].en_exp, vt[v].sent_exp, vt[v].uf_exp);
            if (v == 0) begin
                fcs = {cap[$][7:0], cap[$-1][7:0], cap[$-2][7:0], cap[$-3][7:0]};
                check("ascii_123456789_fcs", fcs, 32'hCBF43926);
            end
        end

        // Back-to-back 64-byte frames with tvalid never dropped
        sel = 2'd0;
        make_frame(2, 64, q);
        make_frame(2, 64, q2);
        model(q, 2'd0, -1, w1, se, ue);
        model(q2, 2'd0, -1, w2, se, ue);
        foreach (w2[i]) w1.push_back(w2[i]);
        b_cap  = cap.size();
        b_sent = sent_tot;
        b_rdy  = rdy_tot;
        send_frame(q, -1);
        send_frame(q2, -1);
        wait_idle();
        cmp_wire("b2b", b_cap, w1);
        check("b2b gap", gaps[$], 13);
        check("b2b tready_cycles", rdy_tot - b_rdy, 128);
        check("b2b frame_sent", sent_tot - b_sent, 2);

        // Reset asserted mid-DATA
        b_sent = sent_tot;
        tvalid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tdata = 8'(i);
            cycles(1);
        end
        check("rst tready_in_data", m_rdy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst tx_en_async", m_en, 0);
        check("rst tready_async", m_rdy, 0);
        tvalid = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        check("rst busy_after", m_busy, 0);
        check("rst no_frame_sent", sent_tot - b_sent, 0);
        cycles(1);
        make_frame(2, 30, q);
        run_frame("post_reset", 2'd0, q, -1, 72, 1, 0);

        for (int r = 0; r < 24; r++) begin
            s    = 2'($urandom_range(0, 2));
            len  = $urandom_range(1, s == 2'd2 ? 80 : 130);
            drop = $urandom_range(0, 4) == 0 ? $urandom_range(0, len - 1) : -1;
            make_frame(2, len, q);
            run_frame($sformatf("rnd%0d", r), s, q, drop, -1, -1, -1);
            cycles($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
